// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: write/read handshake and status bundle for the FIFO read-side stage
interface fifo_rd_ctrl_if #(parameter int ADDR_W = 4, parameter int DATA_W = 8);
  logic              valid_wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_addr;
  modport master (
    output valid_wr, wr_addr, wr_data, rd_en,
    input  rd_data, rd_valid, empty, full, almost_full, count,
    input  err_overflow, err_underflow, err_addr
  );
  modport slave (
    input  valid_wr, wr_addr, wr_data, rd_en,
    output rd_data, rd_valid, empty, full, almost_full, count,
    output err_overflow, err_underflow, err_addr
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO storage, read pointer, occupancy, flags and sticky protocol errors
module fifo_rd_ctrl #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int AFULL_LVL = 14
) (
  input logic          clk,
  input logic          reset,
  fifo_rd_ctrl_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr, exp_wa;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, err_ov, err_un, err_ad;
  logic              wr_acc, rd_acc;
  assign bus.empty         = cnt == '0;
  assign bus.full          = cnt == FULL_CNT;
  assign bus.almost_full   = cnt >= AFULL_CNT;
  assign bus.count         = cnt;
  assign bus.rd_data       = rd_data;
  assign bus.rd_valid      = rd_valid;
  assign bus.err_overflow  = err_ov;
  assign bus.err_underflow = err_un;
  assign bus.err_addr      = err_ad;
  assign wr_acc = bus.valid_wr & ~bus.full;
  assign rd_acc = bus.rd_en & ~bus.empty;
  always_ff @(posedge clk)
    if (wr_acc) mem[bus.wr_addr] <= bus.wr_data;
  // DEPTH is a power of two, so pointer wrap is plain ADDR_W-bit overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_addr  <= '0;
      exp_wa   <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err_ov   <= 1'b0;
      err_un   <= 1'b0;
      err_ad   <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_addr];
        rd_addr <= rd_addr + 1'b1;
      end
      if (wr_acc) exp_wa <= exp_wa + 1'b1;
      if (wr_acc && bus.wr_addr != exp_wa) err_ad <= 1'b1;
      if (bus.valid_wr && bus.full) err_ov <= 1'b1;
      if (bus.rd_en && bus.empty) err_un <= 1'b1;
      cnt <= cnt + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed stimulus with an occupancy/total-count model checked every cycle
module tb_fifo_rd_ctrl;
  localparam int DEPTH = 16;
  logic clk, reset;
  int total = 0, bad = 0;
  fifo_rd_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();
  fifo_rd_ctrl #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(8), .AFULL_LVL(14)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // model: occupancy from totals of accepted writes/reads; storage addressed as written
  logic [7:0] m_mem [DEPTH];
  int m_cnt, m_wtot, m_rtot;
  logic [7:0] m_rd;
  logic m_rv, m_eo, m_eu, m_ea;
  wire m_wa = bus.valid_wr && m_cnt < DEPTH;
  wire m_ra = bus.rd_en && m_cnt > 0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_cnt <= 0; m_wtot <= 0; m_rtot <= 0;
      m_rd <= 8'h00; m_rv <= 1'b0;
      m_eo <= 1'b0; m_eu <= 1'b0; m_ea <= 1'b0;
    end else begin
      if (m_wa) begin
        m_mem[bus.wr_addr] <= bus.wr_data;
        m_wtot <= m_wtot + 1;
        if (int'(bus.wr_addr) != m_wtot % DEPTH) m_ea <= 1'b1;
      end
      if (bus.valid_wr && m_cnt == DEPTH) m_eo <= 1'b1;
      if (bus.rd_en && m_cnt == 0) m_eu <= 1'b1;
      m_rv <= m_ra;
      if (m_ra) begin
        m_rd <= m_mem[m_rtot % DEPTH];
        m_rtot <= m_rtot + 1;
      end
      m_cnt <= m_cnt + int'(m_wa) - int'(m_ra);
    end

  always @(negedge clk) begin
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("full", 32'(bus.full), 32'(m_cnt == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(m_cnt >= 14));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
    chk("err_overflow", 32'(bus.err_overflow), 32'(m_eo));
    chk("err_underflow", 32'(bus.err_underflow), 32'(m_eu));
    chk("err_addr", 32'(bus.err_addr), 32'(m_ea));
  end

  task automatic step(input logic vw, input int a, input int d, input logic re);
    bus.valid_wr = vw;
    bus.wr_addr  = 4'(a);
    bus.wr_data  = 8'(d);
    bus.rd_en    = re;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.valid_wr = 1'b0; bus.rd_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    reset = 1'b1;
    #1;
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_errs", {29'd0, bus.err_overflow, bus.err_underflow, bus.err_addr}, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.valid_wr = 1'b0; bus.rd_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("init_full", 32'(bus.full), 0);
    chk("init_af", 32'(bus.almost_full), 0);
    chk("init_rd_data", 32'(bus.rd_data), 0);
    reset = 1'b0;
    // fill
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i, i, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_af", 32'(bus.almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_errs", {29'd0, bus.err_overflow, bus.err_underflow, bus.err_addr}, 0);
    // drain
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 0, 0, 1'b1);
      chk("drain_valid", 32'(bus.rd_valid), 1);
      chk("drain_data", 32'(bus.rd_data), 32'(i));
    end
    step(1'b0, 0, 0, 1'b0);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_valid_off", 32'(bus.rd_valid), 0);
    // overflow
    for (int i = 0; i < 16; i++) step(1'b1, i, 8'h10 + i, 1'b0);
    step(1'b1, 0, 8'hAA, 1'b0);
    chk("ovf_err", 32'(bus.err_overflow), 1);
    chk("ovf_count", 32'(bus.count), 16);
    step(1'b1, 0, 8'hBB, 1'b1);
    chk("ovf_rw_count", 32'(bus.count), 15);
    chk("ovf_rw_data", 32'(bus.rd_data), 32'h10);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 0, 0, 1'b1);
      chk("ovf_drain", 32'(bus.rd_data), 32'(8'h10 + i));
    end
    // underflow with simultaneous write
    step(1'b1, 0, 8'h55, 1'b1);
    chk("unf_err", 32'(bus.err_underflow), 1);
    chk("unf_valid", 32'(bus.rd_valid), 0);
    chk("unf_count", 32'(bus.count), 1);
    step(1'b0, 0, 0, 1'b1);
    chk("unf_valid2", 32'(bus.rd_valid), 1);
    chk("unf_data", 32'(bus.rd_data), 32'h55);
    do_reset();
    // address check: addr 5 presented where 3 is expected
    for (int i = 0; i < 3; i++) step(1'b1, i, 8'h30 + i, 1'b0);
    chk("addr_clean", 32'(bus.err_addr), 0);
    step(1'b1, 5, 8'h77, 1'b0);
    chk("addr_err", 32'(bus.err_addr), 1);
    step(1'b1, 4, 8'h44, 1'b0);
    step(1'b1, 6, 8'h66, 1'b0);
    chk("addr_count", 32'(bus.count), 6);
    begin
      logic [7:0] exp_rd [6] = '{8'h30, 8'h31, 8'h32, 8'h13, 8'h44, 8'h77};
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 0, 0, 1'b1);
        chk("addr_read", 32'(bus.rd_data), 32'(exp_rd[i]));
      end
    end
    do_reset();
    // streaming across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, i, 8'h80 + i, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, (4 + k) % 16, 8'h84 + k, 1'b1);
      chk("stream_count", 32'(bus.count), 4);
      chk("stream_data", 32'(bus.rd_data), 32'(8'h80 + k));
    end
    step(1'b0, 0, 0, 1'b0);
    chk("stream_errs", {29'd0, bus.err_overflow, bus.err_underflow, bus.err_addr}, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
